// File: rtl/uart_tx_fifo.sv
// Buffered RS-232 transmitter: write FIFO feeding a configurable-format serialiser
// (5..8 data bits, optional parity, 1 or 2 stop bits) with an integer bit-period timer.
module uart_tx_fifo #(
  parameter int ClkFrequency  = 20000000,
  parameter int Baud          = 38400,
  parameter int DataBits      = 8,
  parameter int Parity        = 0,
  parameter int StopBits      = 1,
  parameter int FifoDepthLog2 = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     TxD_start,
  input  logic [7:0]               TxD_data,
  output logic                     TxD,
  output logic                     TxD_busy,
  output logic                     TxD_full,
  output logic [FifoDepthLog2:0]   TxD_count,
  output logic                     TxD_overflow
);

  localparam int Div    = (ClkFrequency + Baud / 2) / Baud;
  localparam int TimerW = (Div > 1) ? $clog2(Div) : 1;
  localparam int Depth  = 1 << FifoDepthLog2;
  localparam int CntW   = FifoDepthLog2 + 1;
  localparam logic [7:0] DataMask = 8'((1 << DataBits) - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                     state, nextState;
  logic [TimerW-1:0]          timer;
  logic [2:0]                 bitIdx, nextBitIdx;
  logic                       stopIdx, nextStopIdx;
  logic [7:0]                 charReg;
  logic                       nextTxD;
  logic                       tick, pop, push, empty, full, parityBit;

  logic [7:0]                 mem [Depth];
  logic [FifoDepthLog2-1:0]   wrPtr, rdPtr;
  logic [FifoDepthLog2:0]     count;
  logic                       overflow;

  assign tick  = (timer == TimerW'(Div - 1));
  assign empty = (count == '0);
  assign full  = (count == CntW'(Depth));
  assign push  = TxD_start & ~full;

  // Upper bits of charReg are masked to zero, so a full-width XOR covers only the data bits.
  assign parityBit = (Parity == 1) ? ~(^charReg) : (^charReg);

  always_comb begin
    nextState   = state;
    nextBitIdx  = bitIdx;
    nextStopIdx = stopIdx;
    pop         = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          nextState = START;
          pop       = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          nextState  = DATA;
          nextBitIdx = '0;
        end
      end
      DATA: begin
        if (tick) begin
          if (bitIdx == 3'(DataBits - 1)) begin
            nextState   = (Parity != 0) ? PARITY : STOP;
            nextStopIdx = 1'b0;
          end else begin
            nextBitIdx = bitIdx + 3'd1;
          end
        end
      end
      PARITY: begin
        if (tick) begin
          nextState   = STOP;
          nextStopIdx = 1'b0;
        end
      end
      STOP: begin
        if (tick) begin
          if (stopIdx == 1'(StopBits - 1)) begin
            if (!empty) begin
              nextState = START;
              pop       = 1'b1;
            end else begin
              nextState = IDLE;
            end
          end else begin
            nextStopIdx = 1'b1;
          end
        end
      end
      default: nextState = IDLE;
    endcase

    // Line level is derived from the destination state so TxD can be registered without lag.
    case (nextState)
      START:   nextTxD = 1'b0;
      DATA:    nextTxD = charReg[nextBitIdx];
      PARITY:  nextTxD = parityBit;
      default: nextTxD = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      timer   <= '0;
      bitIdx  <= '0;
      stopIdx <= 1'b0;
      charReg <= '0;
      TxD     <= 1'b1;
    end else begin
      state   <= nextState;
      bitIdx  <= nextBitIdx;
      stopIdx <= nextStopIdx;
      TxD     <= nextTxD;
      if (state == IDLE || tick)
        timer <= '0;
      else
        timer <= timer + 1'b1;
      if (pop)
        charReg <= mem[rdPtr] & DataMask;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wrPtr] <= TxD_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push)
        wrPtr <= wrPtr + 1'b1;
      if (pop)
        rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (TxD_start && full)
        overflow <= 1'b1;
    end
  end

  assign TxD_busy     = (state != IDLE) || !empty;
  assign TxD_full     = full;
  assign TxD_count    = count;
  assign TxD_overflow = overflow;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four format variants at DIV=16, a frame-table check, hand-written
// FIFO/reset corner sequences and a random run compared every cycle with a frame-level model.
module tb_uart_tx_fifo;

  localparam int NDUT = 4;
  localparam int DIV  = 16;

  function automatic int cfgDataBits(int k);
    return (k == 3) ? 5 : 8;
  endfunction
  function automatic int cfgParity(int k);
    if (k == 1) return 2;
    if (k == 2) return 1;
    return 0;
  endfunction
  function automatic int cfgStop(int k);
    return (k == 1 || k == 2) ? 2 : 1;
  endfunction
  function automatic int cfgDepthLog2(int k);
    return (k == 2) ? 4 : 2;
  endfunction

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data = 8'h00;
  logic       start [NDUT];
  logic       txd   [NDUT];
  logic       busy  [NDUT];
  logic       full  [NDUT];
  logic       ovf   [NDUT];
  logic [4:0] cnt   [NDUT];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : gDut
    localparam int FD = cfgDepthLog2(g);
    logic [FD:0] c;
    uart_tx_fifo #(
      .ClkFrequency(16),
      .Baud(1),
      .DataBits(cfgDataBits(g)),
      .Parity(cfgParity(g)),
      .StopBits(cfgStop(g)),
      .FifoDepthLog2(FD)
    ) dut (
      .clk(clk),
      .reset(reset),
      .TxD_start(start[g]),
      .TxD_data(data),
      .TxD(txd[g]),
      .TxD_busy(busy[g]),
      .TxD_full(full[g]),
      .TxD_count(c),
      .TxD_overflow(ovf[g])
    );
    assign cnt[g] = 5'(c);
  end

  // Frame-level reference: queue of accepted characters plus position within the current frame.
  int unsigned mQ   [NDUT][16];
  int          mCnt [NDUT];
  bit          mAct [NDUT];
  int          mPos [NDUT];
  int unsigned mCh  [NDUT];
  bit          mOvf [NDUT];

  function automatic int frameLen(int k);
    return DIV * (1 + cfgDataBits(k) + ((cfgParity(k) != 0) ? 1 : 0) + cfgStop(k));
  endfunction

  function automatic bit lineBit(int k, int unsigned ch, int b);
    int db = cfgDataBits(k);
    int ones = 0;
    for (int i = 0; i < db; i++) ones += int'((ch >> i) & 1);
    if (b == 0) return 1'b0;
    if (b <= db) return ((ch >> (b - 1)) & 1) != 0;
    if (cfgParity(k) != 0 && b == db + 1)
      return (cfgParity(k) == 2) ? (ones % 2 == 1) : (ones % 2 == 0);
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    int depth;
    bit frameEnd, doPop, doPush;
    int unsigned popped;
    cyc++;
    for (int k = 0; k < NDUT; k++) begin
      if (reset) begin
        mCnt[k] = 0; mAct[k] = 0; mPos[k] = 0; mOvf[k] = 0;
      end else begin
        depth    = 1 << cfgDepthLog2(k);
        frameEnd = mAct[k] && (mPos[k] == frameLen(k) - 1);
        doPop    = (mCnt[k] > 0) && (!mAct[k] || frameEnd);
        doPush   = start[k] && (mCnt[k] < depth);
        popped   = mQ[k][0];
        if (start[k] && mCnt[k] == depth) mOvf[k] = 1;
        if (doPop) begin
          for (int i = 0; i < 15; i++) mQ[k][i] = mQ[k][i+1];
          mCnt[k]--;
        end
        if (doPush) begin
          mQ[k][mCnt[k]] = int'(data);
          mCnt[k]++;
        end
        if (doPop) begin
          mAct[k] = 1; mPos[k] = 0; mCh[k] = popped;
        end else if (frameEnd) begin
          mAct[k] = 0;
        end else if (mAct[k]) begin
          mPos[k]++;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [8:0] got, exp;
    if (cyc > 0) begin
      for (int k = 0; k < NDUT; k++) begin
        got = {txd[k], busy[k], full[k], ovf[k], cnt[k]};
        exp = {(mAct[k] ? lineBit(k, mCh[k], mPos[k] / DIV) : 1'b1),
               (mAct[k] || mCnt[k] > 0),
               (mCnt[k] == (1 << cfgDepthLog2(k))),
               mOvf[k],
               5'(mCnt[k])};
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL model_dut%0d cycle %0d: got %b expected %b (txd busy full ovf count)",
                   k, cyc, got, exp);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    while ((busy[0] | busy[1] | busy[2] | busy[3]) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle", 32'(busy[0] | busy[1] | busy[2] | busy[3]), 0);
  endtask

  task automatic pulseReset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Line bits listed first-bit-at-LSB: start, data LSB first, parity, stop(s).
  typedef struct {
    int         k;
    logic [7:0] d;
    logic [11:0] bits;
    int         n;
  } vec_t;
  vec_t vecs [8];

  task automatic runVec(input int i);
    vec_t v = vecs[i];
    waitIdle(2000);
    @(negedge clk);
    data = v.d;
    start[v.k] = 1'b1;
    @(negedge clk);
    start[v.k] = 1'b0;
    @(negedge clk);
    check($sformatf("vec%0d_start_low", i), 32'(txd[v.k]), 0);
    repeat (7) @(negedge clk);
    for (int b = 0; b < v.n; b++) begin
      if (b > 0) repeat (DIV) @(negedge clk);
      check($sformatf("vec%0d_bit%0d", i, b), 32'(txd[v.k]), 32'(v.bits[b]));
    end
    repeat (8) @(negedge clk);
    check($sformatf("vec%0d_busy_last", i), 32'(busy[v.k]), 1);
    @(negedge clk);
    check($sformatf("vec%0d_busy_end", i), 32'(busy[v.k]), 0);
    check($sformatf("vec%0d_idle_high", i), 32'(txd[v.k]), 1);
  endtask

  initial begin
    int peak;
    int n;
    bit sawFull;
    logic [7:0] vals [6];

    for (int k = 0; k < NDUT; k++) start[k] = 1'b0;

    vecs[0] = '{k: 0, d: 8'h55, bits: 12'h2AA, n: 10};
    vecs[1] = '{k: 0, d: 8'hA3, bits: 12'h346, n: 10};
    vecs[2] = '{k: 1, d: 8'h03, bits: 12'hC06, n: 12};
    vecs[3] = '{k: 1, d: 8'h80, bits: 12'hF00, n: 12};
    vecs[4] = '{k: 2, d: 8'h03, bits: 12'hE06, n: 12};
    vecs[5] = '{k: 2, d: 8'hE5, bits: 12'hDCA, n: 12};
    vecs[6] = '{k: 3, d: 8'hFF, bits: 12'h07E, n: 7};
    vecs[7] = '{k: 3, d: 8'h0A, bits: 12'h054, n: 7};
    vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

    repeat (3) @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("rst_txd%0d", k),   32'(txd[k]), 1);
      check($sformatf("rst_busy%0d", k),  32'(busy[k]), 0);
      check($sformatf("rst_full%0d", k),  32'(full[k]), 0);
      check($sformatf("rst_count%0d", k), 32'(cnt[k]), 0);
      check($sformatf("rst_ovf%0d", k),   32'(ovf[k]), 0);
    end
    reset = 1'b0;

    for (int i = 0; i < 8; i++) runVec(i);

    // Six consecutive writes into a depth-4 FIFO: one pop at E1, so five accepted, one dropped.
    waitIdle(2000);
    peak = 0;
    sawFull = 0;
    for (int i = 0; i < 6; i++) begin
      data = vals[i];
      start[0] = 1'b1;
      @(negedge clk);
      if (int'(cnt[0]) > peak) peak = int'(cnt[0]);
      sawFull |= full[0];
    end
    start[0] = 1'b0;
    check("burst_peak_count", 32'(peak), 4);
    check("burst_saw_full", 32'(sawFull), 1);
    check("burst_overflow", 32'(ovf[0]), 1);
    n = 0;
    while (busy[0] && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("burst_busy_len", 32'(n), 796);

    // Push while full on the same edge as the pop that ends the first frame.
    pulseReset();
    check("pf_ovf_cleared", 32'(ovf[0]), 0);
    for (int i = 0; i < 5; i++) begin
      data = vals[i];
      start[0] = 1'b1;
      @(negedge clk);
    end
    start[0] = 1'b0;
    repeat (156) @(negedge clk);
    check("pf_full_before", 32'(full[0]), 1);
    data = 8'hEE;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    check("pf_count_after", 32'(cnt[0]), 3);
    check("pf_full_after", 32'(full[0]), 0);
    check("pf_overflow", 32'(ovf[0]), 1);
    waitIdle(3000);

    // Reset in the middle of data bit 3 with characters still queued.
    pulseReset();
    for (int i = 0; i < 3; i++) begin
      data = vals[i];
      start[0] = 1'b1;
      @(negedge clk);
    end
    start[0] = 1'b0;
    repeat (68) @(negedge clk);
    check("mid_pre_count", 32'(cnt[0]), 2);
    reset = 1'b1;
    @(negedge clk);
    check("mid_txd", 32'(txd[0]), 1);
    check("mid_busy", 32'(busy[0]), 0);
    check("mid_count", 32'(cnt[0]), 0);
    reset = 1'b0;
    runVec(0);

    // Random traffic on all variants, light then heavy enough to overflow.
    for (int c = 0; c < 4000; c++) begin
      data = 8'($urandom);
      for (int k = 0; k < NDUT; k++)
        start[k] = ($urandom_range(0, 99) < ((c < 2000) ? 1 : 6));
      if ($urandom_range(0, 1999) == 0) reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
    end
    for (int k = 0; k < NDUT; k++) start[k] = 1'b0;
    waitIdle(6000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
